// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose: Sequences one memory request at a time from the execute stage onto
//   a word-wide, big-endian data memory. Loads take one read cycle. Full-word
//   stores take one write cycle. Byte and halfword stores read the word first
//   and write back the merged word. Misaligned addresses and illegal opcodes
//   go straight to a response with err set and never touch memory.
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous active-high reset
//   req_valid      in   1   request present
//   req_ready      out  1   request accepted when req_valid && req_ready
//   op             in   4   opcode, bit 3 = store (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   addr           in  32   byte address (big-endian lanes)
//   wdata          in  32   store data, right-justified for SB/SH
//   rsp_valid      out  1   one-cycle response strobe
//   rdata          out 32   extended load result, 0 for stores and errors
//   err            out  1   misaligned or illegal request
//   busy           out  1   state is not IDLE
//   mem_address    out 32   word index {2'b00, addr[31:2]}
//   mem_write_data out 32   write word, 0 outside WR
//   mem_MemWrite   out  1   write enable (WR only)
//   mem_MemRead    out  1   read enable (RD only)
//   mem_read_data  in  32   combinational read word
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | ready for a request
// RD    | memory read cycle (loads, and the read half of SB/SH)
// WR    | memory write cycle (SW, and the write half of SB/SH)
// RSP   | one-cycle response strobe, then back to IDLE
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Only the parts of the request needed after acceptance are kept: the
  // opcode, the byte offset and the low halfword of store data (SW data is
  // consumed in the acceptance cycle itself).
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_lo_q, wdata_lo_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_rd_q, mem_rd_d;

  logic accept;
  logic req_err;

  // ---------------------------------------------------------------------------
  // Opcode helpers
  // ---------------------------------------------------------------------------
  function automatic logic op_legal(input logic [3:0] o);
    logic ok;
    case (o)
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1011: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // op[1:0] encodes the access size: 00 byte, 01 halfword, 11 word.
  function automatic logic misaligned(input logic [3:0] o, input logic [1:0] off);
    logic m;
    case (o[1:0])
      2'b01:   m = off[0];
      2'b11:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [3:0]  o,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (o[1:0])
      2'b00:   r = o[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = o[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Read-modify-write merge for SB (op[0]=0) and SH (op[0]=1).
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [3:0]  o,
                                              input logic [1:0]  off,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (o[0]) begin
      if (off[1]) r[15:0]  = wd;
      else        r[31:16] = wd;
    end else begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_err   = !op_legal(op) || misaligned(op, addr[1:0]);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)           state_d = S_RSP;
          else if (op == 4'b1011) state_d = S_WR;
          else                   state_d = S_RD;
        end
      end
      S_RD:    state_d = op_q[3] ? S_WR : S_RSP;
      S_WR:    state_d = S_RSP;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: everything is computed from the upcoming state so the
  // memory strobes and the response are flops, aligned with the state itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d        = op_q;
    off_d       = off_q;
    wdata_lo_d  = wdata_lo_q;
    mem_addr_d  = mem_addr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    mem_rd_d    = (state_d == S_RD);
    mem_wr_d    = (state_d == S_WR);
    mem_wdata_d = 32'h0;

    if (accept) begin
      op_d       = op;
      off_d      = addr[1:0];
      wdata_lo_d = wdata[15:0];
      mem_addr_d = {2'b00, addr[31:2]};
    end

    if (state_d == S_WR) begin
      // SW arrives straight from IDLE; SB/SH arrive from RD with the read word.
      if (state_q == S_RD) mem_wdata_d = store_merge(mem_read_data, op_q, off_q, wdata_lo_q);
      else                 mem_wdata_d = wdata;
    end

    if (state_d == S_RSP) begin
      rsp_valid_d = 1'b1;
      if (state_q == S_IDLE) begin
        err_d   = 1'b1;
        rdata_d = 32'h0;
      end else if (state_q == S_RD) begin
        err_d   = 1'b0;
        rdata_d = load_extend(mem_read_data, op_q, off_q);
      end else begin
        err_d   = 1'b0;
        rdata_d = 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 4'h0;
      off_q       <= 2'b00;
      wdata_lo_q  <= 16'h0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      wdata_lo_q  <= wdata_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rdata          = rdata_q;
  assign err            = err_q;
  assign busy           = (state_q != S_IDLE);
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_MemWrite   = mem_wr_q;
  assign mem_MemRead    = mem_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic [31:0] mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rdata(rdata),
    .err(err), .busy(busy), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .mem_read_data(mem_read_data)
  );

  // Data memory environment: 16 words, aliased on the low index bits.
  logic [31:0] env_mem [0:15];
  assign mem_read_data = env_mem[mem_address[3:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= 32'h0;
    end else if (mem_MemWrite) begin
      env_mem[mem_address[3:0]] <= mem_write_data;
    end
  end

  // Reference model memory (cleared whenever the bench resets the system).
  logic [31:0] ref_mem [0:15];

  function automatic bit ref_legal(input logic [3:0] o);
    return o inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
  endfunction

  function automatic int ref_size(input logic [3:0] o);
    if (o[1:0] == 2'b00) return 1;
    if (o[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_err(input logic [3:0] o, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    return !ref_legal(o) || ((off % ref_size(o)) != 0);
  endfunction

  function automatic int ref_latency(input logic [3:0] o, input logic [31:0] a);
    if (ref_err(o, a)) return 1;
    if (!o[3]) return 2;
    if (ref_size(o) == 4) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [3:0] o,
                                           input logic [31:0] a);
    int sz, off, sh;
    longint w, v, full;
    sz = ref_size(o);
    off = int'(a[1:0]);
    if (sz == 4) return word;
    w = {32'h0, word};
    sh = 8 * (4 - off - sz);
    full = longint'(1) << (8 * sz);
    v = (w >> sh) & (full - 1);
    if (!o[2] && v >= (full / 2)) v = v - full;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [3:0] o,
                                            input logic [31:0] a, input logic [31:0] wd);
    int sz, sh;
    longint w, d, m, r;
    sz = ref_size(o);
    if (sz == 4) return wd;
    sh = 8 * (4 - int'(a[1:0]) - sz);
    w = {32'h0, word};
    d = {32'h0, wd};
    m = ((longint'(1) << (8 * sz)) - 1);
    r = (w & ~(m << sh)) | ((d & m) << sh);
    return r[31:0];
  endfunction

  // Drives one request and monitors it through its response. Observations only.
  task automatic run_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic e,
                         output int nrd, output int nwr, output int rd_k, output int wr_k,
                         output logic [31:0] wd_seen, output logic [31:0] addr_k1,
                         output bit bad_mem);
    lat = -1; rd = 32'h0; e = 1'b0; nrd = 0; nwr = 0; rd_k = -1; wr_k = -1;
    wd_seen = 32'h0; addr_k1 = 32'h0; bad_mem = 1'b0;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; op = o; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; op = 4'($urandom); addr = $urandom; wdata = $urandom;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) addr_k1 = mem_address;
      if (mem_MemRead && mem_MemWrite) bad_mem = 1'b1;
      if (!mem_MemWrite && mem_write_data != 32'h0) bad_mem = 1'b1;
      if ((mem_MemRead || mem_MemWrite) && mem_address != (a >> 2)) bad_mem = 1'b1;
      if (mem_MemRead) begin nrd++; if (rd_k < 0) rd_k = k; end
      if (mem_MemWrite) begin nwr++; wd_seen = mem_write_data; if (wr_k < 0) wr_k = k; end
      if (rsp_valid) begin lat = k; rd = rdata; e = err; break; end
      @(negedge clk);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
  endtask

  // Shared per-request observation variables.
  int lat, nrd, nwr, rd_k, wr_k;
  logic [31:0] rd, wd_seen, addr_k1;
  logic e;
  bit bad_mem;

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    clear_ref();
    n_tests++;
    if ({rsp_valid, err, busy, mem_MemRead, mem_MemWrite, req_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp 000000",
               {rsp_valid, err, busy, mem_MemRead, mem_MemWrite, req_ready});
    end
    n_tests++;
    if ({rdata, mem_address, mem_write_data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h wd=%h exp 0", rdata, mem_address, mem_write_data);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_sw_directed();
    run_req(4'b1011, 32'h8, 32'hDEADBEEF, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
    ref_mem[2] = 32'hDEADBEEF;
    n_tests++;
    if (addr_k1 !== 32'd2) begin n_fail++; $display("FAIL sw_addr: got %h exp 2", addr_k1); end
    n_tests++;
    if (wr_k !== 1 || nwr !== 1 || nrd !== 0) begin
      n_fail++; $display("FAIL sw_strobes: wr_k=%0d nwr=%0d nrd=%0d exp 1 1 0", wr_k, nwr, nrd);
    end
    n_tests++;
    if (wd_seen !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h exp deadbeef", wd_seen); end
    n_tests++;
    if (lat !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL sw_rsp: lat=%0d err=%b exp 2 0", lat, e); end
  endtask

  task automatic test_loads();
    logic [3:0]  ops [3]  = '{4'b0000, 4'b0100, 4'b0001};
    logic [31:0] as  [3]  = '{32'h9, 32'h9, 32'h8};
    logic [31:0] exps[3]  = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFDEAD};
    for (int i = 0; i < 3; i++) begin
      run_req(ops[i], as[i], 32'h0, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
      n_tests++;
      if (rd !== exps[i] || e !== 1'b0) begin
        n_fail++; $display("FAIL load_%0d_rdata: got %h err=%b exp %h err=0", i, rd, e, exps[i]);
      end
      n_tests++;
      if (lat !== 2 || rd_k !== 1 || nrd !== 1 || nwr !== 0 || bad_mem) begin
        n_fail++;
        $display("FAIL load_%0d_timing: lat=%0d rd_k=%0d nrd=%0d nwr=%0d bad=%b exp 2 1 1 0 0",
                 i, lat, rd_k, nrd, nwr, bad_mem);
      end
    end
  endtask

  task automatic test_rmw();
    run_req(4'b1001, 32'hA, 32'h00001234, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
    ref_mem[2] = 32'hDEAD1234;
    n_tests++;
    if (rd_k !== 1 || wr_k !== 2 || lat !== 3) begin
      n_fail++; $display("FAIL sh_timing: rd_k=%0d wr_k=%0d lat=%0d exp 1 2 3", rd_k, wr_k, lat);
    end
    n_tests++;
    if (wd_seen !== 32'hDEAD1234 || bad_mem) begin
      n_fail++; $display("FAIL sh_wdata: got %h bad=%b exp dead1234", wd_seen, bad_mem);
    end
    run_req(4'b0011, 32'h8, 32'h0, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
    n_tests++;
    if (rd !== 32'hDEAD1234) begin n_fail++; $display("FAIL sh_readback: got %h exp dead1234", rd); end
  endtask

  task automatic test_errors();
    logic [3:0]  ops [2] = '{4'b0011, 4'b0111};
    logic [31:0] as  [2] = '{32'h6, 32'h8};
    for (int i = 0; i < 2; i++) begin
      run_req(ops[i], as[i], 32'hFFFF_FFFF, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
      n_tests++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin
        n_fail++; $display("FAIL err_%0d_rsp: lat=%0d err=%b rdata=%h exp 1 1 0", i, lat, e, rd);
      end
      n_tests++;
      if (nrd !== 0 || nwr !== 0 || bad_mem) begin
        n_fail++; $display("FAIL err_%0d_mem: nrd=%0d nwr=%0d bad=%b exp 0 0 0", i, nrd, nwr, bad_mem);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit saw_wr, saw_rsp, saw_ready, saw_rd;
    logic rd_in_rd;
    saw_wr = 0; saw_rsp = 0; saw_ready = 0; saw_rd = 0;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; op = 4'b1000; addr = 32'h4; wdata = 32'hAB;
    @(negedge clk);
    req_valid = 1'b0;
    rd_in_rd = mem_MemRead;
    if (mem_MemWrite) saw_wr = 1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_MemWrite) saw_wr = 1;
      if (mem_MemRead) saw_rd = 1;
      if (rsp_valid) saw_rsp = 1;
      if (req_ready) saw_ready = 1;
    end
    clear_ref();
    n_tests++;
    if (rd_in_rd !== 1'b1) begin n_fail++; $display("FAIL abort_rd_phase: got %b exp 1", rd_in_rd); end
    n_tests++;
    if (saw_wr || saw_rd || saw_rsp || saw_ready) begin
      n_fail++;
      $display("FAIL abort_quiet: wr=%b rd=%b rsp=%b ready=%b exp 0000", saw_wr, saw_rd, saw_rsp, saw_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b exp 1", req_ready); end
    run_req(4'b0011, 32'h4, 32'h0, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
    n_tests++;
    if (lat !== 2 || e !== 1'b0 || rd !== ref_mem[1]) begin
      n_fail++; $display("FAIL abort_lw: lat=%0d err=%b rdata=%h exp 2 0 %h", lat, e, rd, ref_mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_busy = 6'b110110;   // bit 5 = first sampled cycle
    logic [5:0] exp_rsp  = 6'b010010;
    logic [5:0] got_busy, got_rsp;
    logic [31:0] r1, r2;
    run_req(4'b1011, 32'hC,  32'h0BAD_F00D, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
    ref_mem[3] = 32'h0BAD_F00D;
    run_req(4'b1011, 32'h10, 32'h8765_4321, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
    ref_mem[4] = 32'h8765_4321;
    got_busy = '0; got_rsp = '0; r1 = 32'h0; r2 = 32'h0;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; op = 4'b0011; addr = 32'hC;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      got_busy[6-k] = busy;
      got_rsp[6-k]  = rsp_valid;
      if (k == 2) r1 = rdata;
      if (k == 5) r2 = rdata;
      if (k == 1) addr = 32'h10;
      if (k == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if (got_busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy: got %b exp %b", got_busy, exp_busy); end
    n_tests++;
    if (got_rsp !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp: got %b exp %b", got_rsp, exp_rsp); end
    n_tests++;
    if (r1 !== ref_mem[3] || r2 !== ref_mem[4]) begin
      n_fail++; $display("FAIL b2b_rdata: got %h %h exp %h %h", r1, r2, ref_mem[3], ref_mem[4]);
    end
  endtask

  task automatic test_random();
    logic [3:0] legal_ops [8] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
    logic [3:0]  o;
    logic [31:0] a, wd, exp_rd, exp_wd;
    int idx, exp_nrd, exp_nwr;
    bit ex_err;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a = {$urandom_range(0, 1023), 4'(i), 2'b00};
      run_req(4'hB, a, wd, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
      ref_mem[i] = wd;
    end
    for (int n = 0; n < 80; n++) begin
      o  = ($urandom_range(0, 99) < 85) ? legal_ops[$urandom_range(0, 7)] : 4'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd = $urandom;
      idx = int'(a[5:2]);
      ex_err = ref_err(o, a);
      exp_rd = (!ex_err && !o[3]) ? ref_load(ref_mem[idx], o, a) : 32'h0;
      exp_wd = 32'h0;
      exp_nwr = 0;
      exp_nrd = 0;
      if (!ex_err) begin
        if (!o[3] || ref_size(o) < 4) exp_nrd = 1;
        if (o[3]) begin
          exp_nwr = 1;
          exp_wd = ref_store(ref_mem[idx], o, a, wd);
          ref_mem[idx] = exp_wd;
        end
      end
      run_req(o, a, wd, lat, rd, e, nrd, nwr, rd_k, wr_k, wd_seen, addr_k1, bad_mem);
      n_tests++;
      if (lat !== ref_latency(o, a) || e !== ex_err) begin
        n_fail++;
        $display("FAIL rnd_%0d_rsp op=%h a=%h: lat=%0d err=%b exp %0d %b", n, o, a, lat, e, ref_latency(o, a), ex_err);
      end
      n_tests++;
      if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_%0d_rdata op=%h a=%h: got %h exp %h", n, o, a, rd, exp_rd); end
      n_tests++;
      if (nrd !== exp_nrd || nwr !== exp_nwr || bad_mem) begin
        n_fail++;
        $display("FAIL rnd_%0d_mem op=%h: nrd=%0d nwr=%0d bad=%b exp %0d %0d 0", n, o, nrd, nwr, bad_mem, exp_nrd, exp_nwr);
      end
      n_tests++;
      if (addr_k1 !== (a >> 2)) begin n_fail++; $display("FAIL rnd_%0d_addr: got %h exp %h", n, addr_k1, a >> 2); end
      if (exp_nwr == 1) begin
        n_tests++;
        if (wd_seen !== exp_wd) begin n_fail++; $display("FAIL rnd_%0d_wdata op=%h: got %h exp %h", n, o, wd_seen, exp_wd); end
      end
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || rdata !== exp_rd || err !== ex_err) begin
        n_fail++;
        $display("FAIL rnd_%0d_hold: rsp=%b rdata=%h err=%b exp 0 %h %b", n, rsp_valid, rdata, err, exp_rd, ex_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_directed();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; data and address widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  a memory request from the execute stage is present.
REQ-005 req_ready  output  1  unit can accept a request; a transfer occurs when req_valid && req_ready at a rising edge.
REQ-006 op  input  4  operation code (bit 3 = store): 0000 LB, 0001 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1011 SW; all other codes are illegal.
REQ-007 addr  input  32  byte address, big-endian.
REQ-008 wdata  input  32  store data, right-justified for SB/SH.
REQ-009 rsp_valid  output  1  one-cycle response strobe.
REQ-010 rdata  output  32  load result after extension; 0 for stores and errors.
REQ-011 err  output  1  misaligned address or illegal op; valid only with rsp_valid.
REQ-012 busy  output  1  high whenever the state is not IDLE; feeds the pipeline stall.
REQ-013 mem_address  output  32  word index to data_memory, equal to {2'b00, addr[31:2]}.
REQ-014 mem_write_data  output  32  word to data_memory.
REQ-015 mem_MemWrite  output  1  data_memory write enable.
REQ-016 mem_MemRead  output  1  data_memory read enable.
REQ-017 mem_read_data  input  32  combinational read word from data_memory.

Function
REQ-018 The FSM states SHALL be IDLE, RD, WR and RSP; req_ready = 1 only in IDLE and not in reset.
REQ-019 On acceptance, op, addr and wdata SHALL be latched; inputs are then ignored until the unit returns to IDLE.
REQ-020 A misaligned request SHALL set err: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. An illegal op SHALL also set err.
REQ-021 On error: IDLE->RSP with no memory enable asserted; rsp_valid = 1 one cycle after acceptance; err = 1; rdata = 0.
REQ-022 Loads: IDLE->RD->RSP. In RD, mem_MemRead = 1 and mem_read_data is captured at the end of RD. rsp_valid is asserted 2 cycles after acceptance.
REQ-023 SW: IDLE->WR->RSP. In WR, mem_MemWrite = 1 and mem_write_data = wdata. rsp_valid is asserted 2 cycles after acceptance.
REQ-024 SB/SH (read-modify-write): IDLE->RD->WR->RSP. In WR, the captured word SHALL be rewritten with only the addressed byte or halfword replaced. rsp_valid is asserted 3 cycles after acceptance.
REQ-025 Byte lanes (big-endian): offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Halfword offset 0 = [31:16], 2 = [15:0].
REQ-026 Load extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-027 RSP SHALL last exactly one cycle and then go to IDLE; the response is not back-pressured.
REQ-028 All mem_* outputs SHALL be registered, so they are glitch-free and stable for the whole cycle.
REQ-029 mem_MemRead is high only in RD, and mem_MemWrite is high only in WR, each for exactly one cycle. The two SHALL never be high together.
REQ-030 mem_address SHALL hold the latched word index from acceptance until the next acceptance. mem_write_data = 0 outside WR.
REQ-031 rdata and err SHALL hold their values until the next rsp_valid; only rsp_valid qualifies them.

Reset
REQ-032 When reset is sampled high: state = IDLE; rsp_valid, err, busy, mem_MemRead, mem_MemWrite = 0; rdata, mem_address, mem_write_data = 0; req_ready = 0 while reset is high.
REQ-033 Reset mid-operation SHALL abort the request with no further memory enable and no response. A store aborted in RD SHALL never write.
REQ-034 req_ready SHALL be 1 in the first cycle after reset is deasserted.

Verification
REQ-035 SW addr=0x8, wdata=0xDEADBEEF accepted at cycle N -> N+1: mem_address=2, mem_MemWrite=1, mem_write_data=0xDEADBEEF; N+2: rsp_valid=1, err=0.
REQ-036 Word 2 = 0xDEADBEEF; LB addr=0x9 -> RD cycle with mem_MemRead=1, mem_address=2; response rdata=0xFFFFFFAD. LBU addr=0x9 -> rdata=0x000000AD. LH addr=0x8 -> rdata=0xFFFFDEAD.
REQ-037 Word 2 = 0xDEADBEEF; SH addr=0xA, wdata=0x00001234 -> RD at N+1, WR at N+2 with mem_write_data=0xDEAD1234, rsp_valid at N+3. A following LW addr=0x8 -> rdata=0xDEAD1234.
REQ-038 LW addr=0x6 and op=0111 -> each gives rsp_valid at N+1 with err=1, rdata=0; mem_MemRead and mem_MemWrite stay 0 throughout.
REQ-039 SB addr=0x4 with reset asserted during RD -> mem_MemWrite never asserted, no rsp_valid; req_ready=1 in the cycle after reset drops; a new LW then completes normally.
REQ-040 Back-to-back: req_valid held high for two LWs -> the second is accepted in the cycle after the first's RSP; busy=1 exactly during RD and RSP of each.
